// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

    localparam int DEF_WIDTH = 8;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

endpackage

// File: rtl/serial_sub_ctrl_full_subtractor.sv
// One-bit combinational full-subtractor slice.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic diff,
    output logic bout
);

    assign diff = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial (LSB first) unsigned subtractor with IDLE/RUN/DONE control.
module serial_sub_ctrl
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             bor_q, bor_d;
    logic             bout_q, bout_d;

    logic s_diff;
    logic s_bout;

    full_subtractor u_slice (
        .a    (a_q[0]),
        .b    (b_q[0]),
        .bin  (bor_q),
        .diff (s_diff),
        .bout (s_bout)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        diff_d  = diff_q;
        cnt_d   = cnt_q;
        bor_d   = bor_q;
        bout_d  = bout_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    cnt_d   = '0;
                    bor_d   = 1'b0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d    = a_q >> 1;
                b_d    = b_q >> 1;
                diff_d = {s_diff, diff_q[WIDTH-1:1]};
                bor_d  = s_bout;
                // Counter holds on the last bit so it never wraps.
                if (cnt_q == LAST) begin
                    bout_d  = s_bout;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            bor_q   <= 1'b0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            bor_q   <= bor_d;
            bout_q  <= bout_d;
        end
    end

    assign diff       = diff_q;
    assign borrow_out = bout_q;
    assign busy       = (state_q == RUN);
    assign done       = (state_q == DONE);

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Directed bench for serial_sub_ctrl at WIDTH=8.
module tb_serial_sub_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] diff;
    logic       borrow_out;
    logic       busy;
    logic       done;

    int vectors = 0;
    int miscompares = 0;

    logic       mon_en = 1'b0;
    logic       held = 1'b0;
    logic [7:0] hd;
    logic       hb;
    int         ndone;

    always #5 clk = ~clk;

    serial_sub_ctrl #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .diff       (diff),
        .borrow_out (borrow_out),
        .busy       (busy),
        .done       (done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Remaining 7 RUN cycles, the DONE cycle, and the cycle after.
    task automatic finish_op(input logic [7:0] ed, input logic eb);
        start = 1'b0;
        for (int i = 1; i < 8; i++) begin
            tick();
            chk("run_busy", busy, 1);
            chk("run_done", done, 0);
        end
        tick();
        chk("done", done, 1);
        chk("done_busy", busy, 0);
        chk("diff", diff, ed);
        chk("borrow", borrow_out, eb);
        tick();
        chk("post_done", done, 0);
        chk("post_diff", diff, ed);
    endtask

    task automatic run_op(input logic [7:0] av, input logic [7:0] bv,
                          input logic [7:0] ed, input logic eb);
        a = av;
        b = bv;
        start = 1'b1;
        tick();
        chk("accept_busy", busy, 1);
        finish_op(ed, eb);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            vectors++;
            assert (!(done && busy)) else begin
                miscompares++;
                $error("FAIL done_and_busy: observed %0b%0b, expected not 11",
                       done, busy);
            end
            if (!rst_n || busy) begin
                held = 1'b0;
            end else if (done) begin
                held = 1'b1;
                hd = diff;
                hb = borrow_out;
            end else if (held) begin
                vectors++;
                assert ({diff, borrow_out} === {hd, hb}) else begin
                    miscompares++;
                    $error("FAIL hold: observed %0h/%0b, expected %0h/%0b",
                           diff, borrow_out, hd, hb);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        tick();
        tick();
        chk("rst_diff", diff, 0);
        chk("rst_borrow", borrow_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        mon_en = 1'b1;
        rst_n = 1'b1;
        tick();
        chk("idle_busy", busy, 0);

        run_op(8'h5A, 8'h3C, 8'h1E, 1'b0);
        run_op(8'h00, 8'h01, 8'hFF, 1'b1);
        run_op(8'hFF, 8'hFF, 8'h00, 1'b0);

        // Start pulsed mid-run must be ignored.
        a = 8'h10;
        b = 8'h01;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        a = 8'hAA;
        b = 8'h55;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 4; i < 8; i++) begin
            tick();
            chk("ign_busy", busy, 1);
        end
        tick();
        chk("ign_done", done, 1);
        chk("ign_diff", diff, 8'h0F);
        chk("ign_borrow", borrow_out, 0);
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) ndone++;
        end
        chk("ign_extra_done", ndone, 0);
        chk("ign_idle_busy", busy, 0);

        // Start held high: back-to-back operations every 9 cycles.
        a = 8'h80;
        b = 8'h7F;
        start = 1'b1;
        tick();
        chk("bb_accept", busy, 1);
        for (int rep = 0; rep < 3; rep++) begin
            for (int i = 1; i < 8; i++) begin
                tick();
                chk("bb_busy", busy, 1);
            end
            tick();
            chk("bb_done", done, 1);
            chk("bb_busy_low", busy, 0);
            chk("bb_diff", diff, 8'h01);
            chk("bb_borrow", borrow_out, 0);
            if (rep == 2) start = 1'b0;
            tick();
            chk("bb_restart", busy, (rep != 2) ? 1 : 0);
            chk("bb_done_low", done, 0);
        end

        // Reset in the 4th RUN cycle, start held to test priority.
        a = 8'h22;
        b = 8'h11;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        a = 8'h03;
        b = 8'h05;
        start = 1'b1;
        tick();
        chk("ab_busy", busy, 0);
        chk("ab_done", done, 0);
        chk("ab_diff", diff, 0);
        chk("ab_borrow", borrow_out, 0);
        rst_n = 1'b1;
        tick();
        chk("ab_accept", busy, 1);
        chk("ab_nodone", done, 0);
        finish_op(8'hFE, 1'b1);

        tick();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serial_sub_ctrl.md
SERIAL_SUB_CTRL -- requirements
Module: serial_sub_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port: start  input  1  request to begin a subtraction; sampled on a rising edge.
REQ-005 Port: a  input  WIDTH  minuend; sampled only on the edge where start is accepted.
REQ-006 Port: b  input  WIDTH  subtrahend; sampled only on the edge where start is accepted.
REQ-007 Port: diff  output  WIDTH  result, (a - b) mod 2^WIDTH; registered.
REQ-008 Port: borrow_out  output  1  final borrow; 1 means a < b (unsigned); registered.
REQ-009 Port: busy  output  1  high while a subtraction is in progress.
REQ-010 Port: done  output  1  single-cycle pulse marking diff/borrow_out valid.

Function
REQ-011 The block SHALL compute a - b bit-serially, LSB first, one bit per clock, using a single 1-bit full-subtractor slice.
REQ-012 FSM states SHALL be IDLE, RUN and DONE.
REQ-013 IDLE/DONE with start=1: latch a and b into shift registers, clear the bit counter and the borrow flop, go to RUN.
REQ-014 RUN: each edge feeds operand LSBs plus the borrow flop to the slice, shifts the slice difference into diff from the MSB end, stores the slice borrow, and increments the counter.
REQ-015 RUN SHALL go to DONE on the edge that processes bit WIDTH-1; borrow_out SHALL take that edge's slice borrow.
REQ-016 DONE SHALL last exactly one cycle, then go to IDLE, unless start=1, in which case REQ-013 applies.
REQ-017 Latency: start accepted at edge k means done=1 in the cycle after edge k+WIDTH; busy=1 in cycles after edges k .. k+WIDTH-1.
REQ-018 done SHALL be 1 only in DONE; busy SHALL be 1 only in RUN; both are never high together.
REQ-019 start while in RUN SHALL be ignored, with no effect on operands, counter or result.
REQ-020 diff and borrow_out SHALL hold their last values from DONE until the next accepted start.
REQ-021 While in RUN, diff SHALL carry the partial shift contents; it is valid only when done=1 or afterwards per REQ-020.
REQ-022 The bit counter SHALL be $clog2(WIDTH) bits wide and SHALL NOT wrap within one operation.

Reset
REQ-023 rst_n=0 at a rising edge SHALL force: state IDLE, diff 0, borrow_out 0, busy 0, done 0, counter 0, borrow flop 0, operand registers 0.
REQ-024 Reset during RUN SHALL abort the operation with no done pulse; a start on the first edge with rst_n=1 SHALL be accepted.
REQ-025 rst_n SHALL take priority over start on the same edge.

Structure
REQ-026 Package serial_sub_pkg SHALL hold the FSM state typedef (IDLE, RUN, DONE) and the default WIDTH constant.
REQ-027 The bit slice SHALL be one instance of the team's combinational full_subtractor cell (inputs a, b, borrow-in; outputs diff, borrow); no other sub-modules.
REQ-028 All flops SHALL be in a single clocked process with synchronous reset; the slice is purely combinational.

Verification (WIDTH=8)
REQ-029 a=0x5A, b=0x3C, start 1 cycle -> done exactly 8 cycles after the start edge; diff=0x1E, borrow_out=0; busy high for 8 cycles.
REQ-030 a=0x00, b=0x01 -> diff=0xFF, borrow_out=1; a=0xFF, b=0xFF -> diff=0x00, borrow_out=0.
REQ-031 Start accepted with a=0x10, b=0x01; pulse start with a=0xAA, b=0x55 in the 3rd RUN cycle -> result stays 0x0F, borrow 0, and only one done pulse.
REQ-032 Start held high continuously with a=0x80, b=0x7F -> done every 9 cycles, diff=0x01 each time; busy low only during the DONE cycle.
REQ-033 rst_n=0 on the 4th RUN cycle -> next cycle all outputs 0 and state IDLE; no done pulse; then a=0x03, b=0x05 -> diff=0xFE, borrow_out=1.
REQ-034 Check after every edge: done and busy never both 1, and diff/borrow_out stay stable from DONE until the next accepted start.
